trivium_stream: RTL and testbench

- Parametrised Trivium keystream engine; successor to the fixed-width Trivium core.
- Loads an 80-bit key and 80-bit IV, runs the 1152-step initialisation, then emits an unbounded stream of OUT_W-bit keystream blocks.
- Advances UNROLL cipher steps per clock; output uses a valid/acknowledge handshake with backpressure; supports IV resync without reloading the key.
- Sits between the host interface and the data path as the cipher primitive.

---
 rtl/trivium_stream_pkg.sv | 57 +++++
 rtl/trivium_stream_if.sv | 35 +++
 rtl/trivium_stream_update.sv | 40 ++++
 rtl/trivium_stream.sv | 155 +++++++++++++++
 tb/tb_trivium_stream.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trivium_stream_pkg.sv
// Shared definitions for the Trivium keystream engine.
//   - Cipher geometry: key/IV widths, 288-bit state, 1152 initialisation steps.
//   - Register tap positions, zero-based: state bit s(n) lives at index n-1.
//   - FSM state encoding.
//   - load_state(): key/IV placement into the 288-bit state at (re)initialisation.
package trivium_stream_pkg;

    localparam int KEY_W      = 80;
    localparam int IV_W       = 80;
    localparam int ST_W       = 288;
    localparam int INIT_STEPS = 1152;

    // Segment start indices: A = s1..s93, B = s94..s177, C = s178..s288
    localparam int B_LO = 93;
    localparam int C_LO = 177;

    // Segment A taps
    localparam int A_FB    = 65;   // s66
    localparam int A_END   = 92;   // s93
    localparam int A_AND0  = 90;   // s91
    localparam int A_AND1  = 91;   // s92
    localparam int A_CROSS = 170;  // s171

    // Segment B taps
    localparam int B_FB    = 161;  // s162
    localparam int B_END   = 176;  // s177
    localparam int B_AND0  = 174;  // s175
    localparam int B_AND1  = 175;  // s176
    localparam int B_CROSS = 263;  // s264

    // Segment C taps
    localparam int C_FB    = 242;  // s243
    localparam int C_END   = 287;  // s288
    localparam int C_AND0  = 285;  // s286
    localparam int C_AND1  = 286;  // s287
    localparam int C_CROSS = 68;   // s69

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYED,
        S_INIT,
        S_GEN,
        S_HOLD
    } state_t;

    // s1..s80 = key, s94..s173 = IV, s286..s288 = 1, everything else 0
    function automatic logic [ST_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                   input logic [IV_W-1:0]  iv);
        logic [ST_W-1:0] s;
        s                = '0;
        s[KEY_W-1:0]     = key;
        s[B_LO +: IV_W]  = iv;
        s[ST_W-1 -: 3]   = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_stream_if.sv
// Host-side bus of the Trivium keystream engine.
//   Kin/Krdy/Kvld : key load and key-held indication
//   Din/Drdy      : IV load, starts or restarts initialisation
//   BSY           : engine initialising or generating
//   Dout/Dvld/Dack: keystream block with valid/acknowledge handshake
//   Ptxt          : plaintext block, present only when TRIVIUM_XOR_EN is defined
// master = host/consumer side, slave = engine side.
interface trivium_stream_if
    import trivium_stream_pkg::*;
#(
    parameter int OUT_W = 128
);
    logic [KEY_W-1:0] Kin;
    logic             Krdy;
    logic             Kvld;
    logic [IV_W-1:0]  Din;
    logic             Drdy;
    logic             BSY;
    logic [OUT_W-1:0] Dout;
    logic             Dvld;
    logic             Dack;
`ifdef TRIVIUM_XOR_EN
    logic [OUT_W-1:0] Ptxt;

    modport master (output Kin, Krdy, Din, Drdy, Dack, Ptxt,
                    input  Kvld, BSY, Dout, Dvld);
    modport slave  (input  Kin, Krdy, Din, Drdy, Dack, Ptxt,
                    output Kvld, BSY, Dout, Dvld);
`else
    modport master (output Kin, Krdy, Din, Drdy, Dack,
                    input  Kvld, BSY, Dout, Dvld);
    modport slave  (input  Kin, Krdy, Din, Drdy, Dack,
                    output Kvld, BSY, Dout, Dvld);
`endif
endinterface

// File: rtl/trivium_stream_update.sv
// Combinational Trivium round logic: advances the 288-bit state by UNROLL steps.
//   st_i : current state (bit n-1 = s(n))
//   st_o : state after UNROLL steps
//   ks_o : the UNROLL keystream bits; the first step's bit is ks_o[UNROLL-1]
module trivium_stream_update
    import trivium_stream_pkg::*;
#(
    parameter int UNROLL = 8
) (
    input  logic [ST_W-1:0]   st_i,
    output logic [ST_W-1:0]   st_o,
    output logic [UNROLL-1:0] ks_o
);

    logic [ST_W-1:0]   s;
    logic [UNROLL-1:0] ks;
    logic              t1, t2, t3;

    always_comb begin
        s  = st_i;
        ks = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int k = 0; k < UNROLL; k++) begin
            t1 = s[A_FB] ^ s[A_END];
            t2 = s[B_FB] ^ s[B_END];
            t3 = s[C_FB] ^ s[C_END];
            ks[UNROLL-1-k] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[A_AND0] & s[A_AND1]) ^ s[A_CROSS];
            t2 = t2 ^ (s[B_AND0] & s[B_AND1]) ^ s[B_CROSS];
            t3 = t3 ^ (s[C_AND0] & s[C_AND1]) ^ s[C_CROSS];
            // Each segment shifts up by one; feedback enters at its lowest bit
            s = {s[ST_W-2:C_LO], t2, s[C_LO-2:B_LO], t1, s[B_LO-2:0], t3};
        end
        st_o = s;
        ks_o = ks;
    end

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream engine: key load, 1152-step initialisation, then an
// unbounded stream of OUT_W-bit blocks, UNROLL cipher steps per clock.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous reset, active-high
//   EN   : global enable; low freezes all state
//   bus  : trivium_stream_if.slave (key, IV, block handshake)
// Parameters: UNROLL (1..64, divides 1152 and OUT_W), OUT_W (8..512).
// Optional macro TRIVIUM_XOR_EN: Dout = keystream XOR bus.Ptxt, Ptxt sampled
// on the final GEN clock. Without it Dout is raw keystream.
module trivium_stream
    import trivium_stream_pkg::*;
#(
    parameter int UNROLL = 8,
    parameter int OUT_W  = 128
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    trivium_stream_if.slave     bus
);

    localparam int INIT_CYC = INIT_STEPS / UNROLL;
    localparam int GEN_CYC  = OUT_W / UNROLL;
    localparam int INIT_CW  = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam int GEN_CW   = (GEN_CYC > 1) ? $clog2(GEN_CYC) : 1;

    state_t              state_q, state_d;
    logic [KEY_W-1:0]    key_q;
    logic [ST_W-1:0]     st_q;
    logic [OUT_W-1:0]    blk_q;
    logic [OUT_W-1:0]    dout_q;
    logic [INIT_CW-1:0]  init_cnt_q;
    logic [GEN_CW-1:0]   gen_cnt_q;

    logic [ST_W-1:0]     st_upd;
    logic [UNROLL-1:0]   ks;
    logic [OUT_W-1:0]    blk_nxt;
    logic                init_last;
    logic                gen_last;
    logic                resync;

    trivium_stream_update #(.UNROLL(UNROLL)) u_update (
        .st_i (st_q),
        .st_o (st_upd),
        .ks_o (ks)
    );

    // Newest keystream bits enter at the LSB so the first bit ends at the MSB
    generate
        if (OUT_W == UNROLL) begin : g_blk_full
            assign blk_nxt = ks;
        end else begin : g_blk_shift
            assign blk_nxt = {blk_q[OUT_W-UNROLL-1:0], ks};
        end
    endgenerate

    assign init_last = (init_cnt_q == INIT_CW'(INIT_CYC - 1));
    assign gen_last  = (gen_cnt_q == GEN_CW'(GEN_CYC - 1));
    // Drdy while streaming restarts with the stored key; it beats Dack
    assign resync    = bus.Drdy && ((state_q == S_GEN) || (state_q == S_HOLD));

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else if (EN) begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.Krdy) state_d = S_KEYED;
            S_KEYED: if (bus.Drdy) state_d = S_INIT;
            S_INIT:  if (init_last) state_d = S_GEN;
            S_GEN: begin
                if (bus.Drdy)     state_d = S_INIT;
                else if (gen_last) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.Drdy)     state_d = S_INIT;
                else if (bus.Dack) state_d = S_GEN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.Kvld = (state_q != S_IDLE);
        bus.BSY  = (state_q == S_INIT) || (state_q == S_GEN) || (state_q == S_HOLD);
        bus.Dvld = (state_q == S_HOLD);
        bus.Dout = dout_q;
    end

    // Datapath: key, cipher state, block assembly and counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_q      <= '0;
            st_q       <= '0;
            blk_q      <= '0;
            dout_q     <= '0;
            init_cnt_q <= '0;
            gen_cnt_q  <= '0;
        end else if (EN) begin
            if (resync) begin
                st_q       <= load_state(key_q, bus.Din);
                init_cnt_q <= '0;
                gen_cnt_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.Krdy) key_q <= bus.Kin;
                    end
                    S_KEYED: begin
                        if (bus.Krdy) key_q <= bus.Kin;
                        // A same-cycle key update must reach the load
                        if (bus.Drdy) begin
                            st_q       <= load_state(bus.Krdy ? bus.Kin : key_q, bus.Din);
                            init_cnt_q <= '0;
                        end
                    end
                    S_INIT: begin
                        st_q <= st_upd;
                        if (init_last) begin
                            init_cnt_q <= '0;
                            gen_cnt_q  <= '0;
                        end else begin
                            init_cnt_q <= init_cnt_q + INIT_CW'(1);
                        end
                    end
                    S_GEN: begin
                        st_q  <= st_upd;
                        blk_q <= blk_nxt;
                        if (gen_last) begin
                            gen_cnt_q <= '0;
`ifdef TRIVIUM_XOR_EN
                            dout_q    <= blk_nxt ^ bus.Ptxt;
`else
                            dout_q    <= blk_nxt;
`endif
                        end else begin
                            gen_cnt_q <= gen_cnt_q + GEN_CW'(1);
                        end
                    end
                    default: ;  // HOLD: cipher stalled, Dout stable
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream.sv
module tb_trivium_stream;
    localparam int UNROLL   = 8;
    localparam int OUT_W    = 128;
    localparam int INIT_CYC = 1152 / UNROLL;
    localparam int GEN_CYC  = OUT_W / UNROLL;

    logic CLK;
    logic RST;
    logic EN;

    trivium_stream_if #(.OUT_W(OUT_W)) bus();

    trivium_stream #(.UNROLL(UNROLL), .OUT_W(OUT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [OUT_W-1:0] exp_q[$];

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [OUT_W-1:0] act,
                           input logic [OUT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: bit-serial Trivium, s[1..288] ----------------
    bit ms [1:288];

    function automatic bit m_step();
        bit t1, t2, t3, z;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[178] = t2;
        return z;
    endfunction

    function automatic void m_load(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ms[i+1]  = k[i];
            ms[94+i] = v[i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int i = 0; i < 1152; i++) void'(m_step());
    endfunction

    function automatic logic [OUT_W-1:0] m_block();
        logic [OUT_W-1:0] b;
        for (int i = OUT_W - 1; i >= 0; i--) b[i] = m_step();
`ifdef TRIVIUM_XOR_EN
        b = ~b;  // Ptxt is driven all ones
`endif
        return b;
    endfunction

    task automatic push_blocks(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(m_block());
    endtask

    function automatic logic [79:0] rand80();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    // ---------------- monitor: compares each newly presented block ----------------
    bit seen = 1'b0;
    always @(negedge CLK) begin
        if (RST) begin
            seen = 1'b0;
        end else if (bus.Dvld && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL block_unexpected: got %h want none", bus.Dout);
            end else begin
                logic [OUT_W-1:0] e;
                e = exp_q.pop_front();
                chk_blk("block", bus.Dout, e);
            end
        end else if (!bus.Dvld) begin
            seen = 1'b0;
        end
    end

    // Issue Drdy (optionally with Krdy), then run until nblk blocks were seen
    // (Dack tied high, dropped on the last one so it stays held) or, with
    // nblk==0, until abort_at cycles. 'drops' EN-low cycles are scattered,
    // half in INIT and half in GEN.
    task automatic start_run(input logic [79:0] iv, input int nblk, input int exp_lat,
                             input int drops, input int abort_at,
                             input bit new_key, input logic [79:0] key);
        int lat, got, last, b1, b2;
        @(negedge CLK);
        EN       = 1'b1;
        bus.Dack = 1'b1;
        bus.Din  = iv;
        bus.Drdy = 1'b1;
        if (new_key) begin
            bus.Kin  = key;
            bus.Krdy = 1'b1;
        end
        @(negedge CLK);
        bus.Drdy = 1'b0;
        bus.Krdy = 1'b0;
        chk_int("bsy_rise", int'(bus.BSY), 1);
        chk_int("dvld_clear", int'(bus.Dvld), 0);
        lat  = 0;
        got  = 0;
        last = 0;
        b1   = drops / 2;
        b2   = drops - b1;
        forever begin
            if (nblk == 0 && lat >= abort_at) break;
            if (lat > 4000) begin
                total++;
                bad++;
                $display("FAIL block_timeout: got %0d blocks want %0d", got, nblk);
                break;
            end
            EN = 1'b1;
            if (b1 > 0 && lat < 100 && (b1 >= 100 - lat || $urandom_range(0, 7) == 0)) begin
                EN = 1'b0;
                b1--;
            end
            if (b2 > 0 && lat >= 155 && lat < 175 && (b2 >= 175 - lat || $urandom_range(0, 1) == 0)) begin
                EN = 1'b0;
                b2--;
            end
            @(negedge CLK);
            lat++;
            if (bus.Dvld) begin
                got++;
                if (got == 1) chk_int("first_latency", lat, exp_lat);
                else          chk_int("block_gap", lat - last, GEN_CYC + 1);
                last = lat;
                if (got == nblk) begin
                    bus.Dack = 1'b0;
                    break;
                end
            end
        end
        EN = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0]      keyb, iv;
        logic [OUT_W-1:0] held;
        bit               stable;
        int               cnt;

        RST      = 1'b1;
        EN       = 1'b1;
        bus.Kin  = '0;
        bus.Krdy = 1'b0;
        bus.Din  = '0;
        bus.Drdy = 1'b0;
        bus.Dack = 1'b1;
`ifdef TRIVIUM_XOR_EN
        bus.Ptxt = '1;
`endif
        repeat (3) @(negedge CLK);
        chk_int("rst_kvld", int'(bus.Kvld), 0);
        chk_int("rst_bsy", int'(bus.BSY), 0);
        chk_int("rst_dvld", int'(bus.Dvld), 0);
        chk_blk("rst_dout", bus.Dout, '0);
        RST = 1'b0;

        // Key load with Kin = 0
        @(negedge CLK);
        bus.Kin  = '0;
        bus.Krdy = 1'b1;
        @(negedge CLK);
        bus.Krdy = 1'b0;
        chk_int("kvld_after_krdy", int'(bus.Kvld), 1);
        chk_int("bsy_keyed", int'(bus.BSY), 0);
        chk_blk("dout_keyed", bus.Dout, '0);

        // Reference IV, three contiguous blocks with Dack tied high
        iv = 80'h00010203040506070809;
        m_load(80'h0, iv);
        push_blocks(3);
        start_run(iv, 3, INIT_CYC + GEN_CYC, 0, 0, 1'b0, 80'h0);

        // Backpressure: block stays held for 50 cycles
        held   = bus.Dout;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.Dout !== held || bus.Dvld !== 1'b1) stable = 1'b0;
        end
        chk_int("hold_stable", int'(stable), 1);
        chk_int("hold_dvld", int'(bus.Dvld), 1);

        // Single Dack pulse releases the next contiguous block
        push_blocks(1);
        bus.Dack = 1'b1;
        @(negedge CLK);
        bus.Dack = 1'b0;
        chk_int("dvld_after_dack", int'(bus.Dvld), 0);
        cnt = 1;
        while (!bus.Dvld && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
        chk_int("next_block_delay", cnt, GEN_CYC + 1);

        // Krdy while busy must be ignored
        @(negedge CLK);
        bus.Kin  = rand80();
        bus.Krdy = 1'b1;
        @(negedge CLK);
        bus.Krdy = 1'b0;
        chk_int("kvld_busy", int'(bus.Kvld), 1);

        // Resync from HOLD (Dack and Drdy together) with the original key
        iv = rand80();
        m_load(80'h0, iv);
        push_blocks(2);
        start_run(iv, 2, INIT_CYC + GEN_CYC, 0, 0, 1'b0, 80'h0);

        // EN low for 20 scattered cycles in INIT and GEN
        iv = rand80();
        m_load(80'h0, iv);
        push_blocks(2);
        start_run(iv, 2, INIT_CYC + GEN_CYC + 20, 20, 0, 1'b0, 80'h0);

        // Resync while in GEN; the partial block is dropped
        start_run(rand80(), 0, 0, 0, INIT_CYC + GEN_CYC / 2, 1'b0, 80'h0);
        iv = rand80();
        m_load(80'h0, iv);
        push_blocks(2);
        start_run(iv, 2, INIT_CYC + GEN_CYC, 0, 0, 1'b0, 80'h0);

        // Reset in the middle of GEN
        start_run(rand80(), 0, 0, 0, INIT_CYC + 6, 1'b0, 80'h0);
        RST = 1'b1;
        #1;
        chk_int("midrst_kvld", int'(bus.Kvld), 0);
        chk_int("midrst_bsy", int'(bus.BSY), 0);
        chk_int("midrst_dvld", int'(bus.Dvld), 0);
        chk_blk("midrst_dout", bus.Dout, '0);
        @(negedge CLK);
        RST      = 1'b0;
        bus.Dack = 1'b1;
        bus.Drdy = 1'b1;
        @(negedge CLK);
        bus.Drdy = 1'b0;
        @(negedge CLK);
        chk_int("idle_drdy_bsy", int'(bus.BSY), 0);
        chk_int("idle_drdy_kvld", int'(bus.Kvld), 0);

        // New key, then Krdy and Drdy together: load must use the newer key
        @(negedge CLK);
        bus.Kin  = rand80();
        bus.Krdy = 1'b1;
        @(negedge CLK);
        bus.Krdy = 1'b0;
        chk_int("kvld_rekey", int'(bus.Kvld), 1);
        keyb = rand80();
        iv   = rand80();
        m_load(keyb, iv);
        push_blocks(2);
        start_run(iv, 2, INIT_CYC + GEN_CYC, 0, 0, 1'b1, keyb);

        repeat (3) @(negedge CLK);
        chk_int("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
